// File: rtl/div_unit_pkg.sv
// ----------------------------------------------------------------------------
// div_unit_pkg
// Shared types and constants for the iterative EX-stage divider.
//   - div_state_e       : divider FSM states (2-bit encoding)
//   - REG_BUS / DOUBLE_REG_BUS : operand and result widths
//   - DIV_RESULT_READY / DIV_RESULT_NOT_READY, DIV_START / DIV_STOP
//   - negate32()        : two's-complement negate helper
// ----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // Number of restoring iterations for a 32-bit quotient.
    localparam logic [5:0] DIV_ITERATIONS = 6'd32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement negation, modulo 2^32.
    function automatic logic [REG_BUS-1:0] negate32(input logic [REG_BUS-1:0] value);
        negate32 = (~value) + 32'd1;
    endfunction

endpackage

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Iterative 32-bit radix-2 restoring divider serving DIV (signed) and DIVU.
// Operands are converted to magnitudes on start, 32 iterations produce the
// unsigned quotient/remainder, and a final fix-up restores the signs.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-low reset
//   signed_div_i in   1 = signed divide, 0 = unsigned
//   opdata1_i    in   [31:0] dividend
//   opdata2_i    in   [31:0] divisor
//   start_i      in   divide request, held high until result consumed
//   annul_i      in   abort the in-flight divide
//   result_o     out  [63:0] {remainder, quotient}, registered
//   ready_o      out  result_o valid, registered
// ----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e                state_q,    state_d;
    logic [5:0]                cnt_q,      cnt_d;
    // [64:33] partial remainder, [31:0] quotient bits shifted in from the LSB.
    logic [64:0]               dividend_q, dividend_d;
    logic [REG_BUS-1:0]        divisor_q,  divisor_d;
    // Sign corrections captured at start so the fix-up does not depend on
    // EX keeping signed_div_i/operands stable.
    logic                      neg_quot_q, neg_quot_d;
    logic                      neg_rem_q,  neg_rem_d;
    logic [DOUBLE_REG_BUS-1:0] result_q,   result_d;
    logic                      ready_q,    ready_d;

    logic [32:0]               trial_s;
    logic [REG_BUS-1:0]        abs_op1_s;
    logic [REG_BUS-1:0]        abs_op2_s;
    logic [REG_BUS-1:0]        quot_raw_s;
    logic [REG_BUS-1:0]        rem_raw_s;

    // Trial subtraction; trial_s[32] is the borrow.
    assign trial_s    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    assign abs_op1_s  = (signed_div_i && opdata1_i[31]) ? negate32(opdata1_i) : opdata1_i;
    assign abs_op2_s  = (signed_div_i && opdata2_i[31]) ? negate32(opdata2_i) : opdata2_i;
    assign quot_raw_s = dividend_q[31:0];
    assign rem_raw_s  = dividend_q[64:33];

    // Next-state, datapath and output computation for the divider FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = 6'd0;
                        dividend_d = {32'd0, abs_op1_s, 1'b0};
                        divisor_d  = abs_op2_s;
                        neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = signed_div_i && opdata1_i[31];
                    end
                end else begin
                    state_d = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
                // No trap: the result is simply zero.
                state_d    = DIV_END;
                dividend_d = 65'd0;
                result_d   = 64'd0;
                ready_d    = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = 6'd0;
                    ready_d = DIV_RESULT_NOT_READY;
                end else if (cnt_q < DIV_ITERATIONS) begin
                    if (trial_s[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {trial_s[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d[31:0]  = neg_quot_q ? negate32(quot_raw_s) : quot_raw_s;
                    result_d[63:32] = neg_rem_q  ? negate32(rem_raw_s)  : rem_raw_s;
                    ready_d         = DIV_RESULT_READY;
                    cnt_d           = 6'd0;
                    state_d         = DIV_END;
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = 64'd0;
                end else begin
                    state_d = DIV_END;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                cnt_d    = 6'd0;
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = 64'd0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: a table of divides with hand-derived
// results, a scoreboard queue of expected {result, latency}, and hand-written
// sequences for annul, mid-operation reset and result hold.
// ----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          edges;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          edges;
        string       nm;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[11];

    div_unit dut (
        .clk         (clk),
        .rst         (rst_n),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive a divide, push its expectation, wait for ready, pop and compare.
    // start_i is left high on return.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_edges, input string nm);
        int  edges;
        bit  got;
        sb_t item;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back('{exp, exp_edges, nm});
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready_o not seen within %0d edges", nm, edges);
            void'(sb_q.pop_front());
        end else begin
            item = sb_q.pop_front();
            check64({item.nm, "_result"}, result_o, item.exp);
            check64({item.nm, "_latency"}, 64'(edges), 64'(item.edges));
        end
    endtask

    // Drop start_i after a completed divide and check the output clears.
    task automatic release_start(input string nm);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check64({nm, "_ready_clear"}, {63'd0, ready_o}, 64'd0);
        check64({nm, "_result_clear"}, result_o, 64'd0);
    endtask

    // Global time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen_ready;
        logic [63:0] held;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 34};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 34};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   {32'h0000000F, 32'h0FFFFFFF}, 34};
        vecs[5]  = '{1'b0, 32'h12345678,   32'd0,          64'd0,                        2};
        vecs[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 34};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h00000000, 32'h00000001}, 34};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,         {32'h00000005, 32'h00000000}, 34};
        vecs[9]  = '{1'b1, 32'h80000000,   32'd1,          {32'h00000000, 32'h80000000}, 34};
        vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h00000000}, 34};

        rst_n        = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_ready", {63'd0, ready_o}, 64'd0);
        check64("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven divides.
        for (int i = 0; i < 11; i++) begin
            do_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].edges,
                   $sformatf("vec%0d", i));
            release_start($sformatf("vec%0d", i));
        end

        // Start together with annul in the free state: nothing happens.
        @(negedge clk);
        opdata1_i = 32'd9; opdata2_i = 32'd3; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        seen_ready = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen_ready++;
        end
        check64("start_annul_free", 64'(seen_ready), 64'd0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;

        // Annul mid-divide, then an immediate fresh divide.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        seen_ready = 0;
        repeat (11) begin
            @(posedge clk); #1;
            if (ready_o) seen_ready++;
        end
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        if (ready_o) seen_ready++;
        annul_i = 1'b0;
        check64("annul_no_ready", 64'(seen_ready), 64'd0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000010, {32'h0000000F, 32'h0FFFFFFF}, 34, "after_annul");
        release_start("after_annul");

        // Start dropped during iterations is ignored.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        seen_ready = 0;
        for (int k = 0; k < 60 && seen_ready == 0; k++) begin
            @(posedge clk); #1;
            if (ready_o) seen_ready = 1;
        end
        check64("start_drop_completes", 64'(seen_ready), 64'd1);
        check64("start_drop_result", result_o, {32'h00000002, 32'h0000000E});
        release_start("start_drop");

        // Reset during iteration 20 clears without a clock edge.
        @(negedge clk);
        opdata1_i = 32'h12345678; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check64("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        check64("rst_mid_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34, "after_rst");

        // Hold start in the end state for 5 cycles: output stays stable.
        held = {32'h00000000, 32'h80000000};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check64($sformatf("hold%0d_ready", k), {63'd0, ready_o}, 64'd1);
            check64($sformatf("hold%0d_result", k), result_o, held);
        end

        // Asynchronous reset while a result is presented.
        #2;
        rst_n = 1'b0;
        #1;
        check64("rst_end_ready", {63'd0, ready_o}, 64'd0);
        check64("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Divide-by-zero start/stop handshake once more after reset.
        do_div(1'b1, 32'h12345678, 32'd0, 64'd0, 2, "dbz_after_rst");
        release_start("dbz_after_rst");

        check64("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
